// File: rtl/lsu_pkg.sv
// Shared types, I/O slot map and load-lane helper for the LSU.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_funct3_e;

  typedef enum logic [1:0] {
    RGN_DMEM,
    RGN_OUT,
    RGN_SW,
    RGN_NONE
  } lsu_region_e;

  // I/O is decoded on addr[31:4]: each register owns a 16-byte slot
  localparam logic [27:0] SLOT_LEDR = 28'h000_0700;
  localparam logic [27:0] SLOT_LEDG = 28'h000_0701;
  localparam logic [27:0] SLOT_HEX0 = 28'h000_0702;
  localparam logic [27:0] SLOT_LCD  = 28'h000_0710;
  localparam logic [27:0] SLOT_SW   = 28'h000_0780;

  function automatic logic [31:0] lane_extract(input logic [31:0] w,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      LSU_B:   lane_extract = {{24{b[7]}}, b};
      LSU_BU:  lane_extract = {24'h0, b};
      LSU_H:   lane_extract = {{16{h[15]}}, h};
      LSU_HU:  lane_extract = {16'h0, h};
      default: lane_extract = w;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Word-organised data memory: byte-strobed writes, registered read.
module lsu_dmem #(
  parameter int    DMEM_BYTES = 2048,
  parameter string INIT_FILE  = ""
) (
  input  logic                              clk_i,
  input  logic                              we_i,
  input  logic                              re_i,
  input  logic [$clog2(DMEM_BYTES/4)-1:0]   idx_i,
  input  logic [3:0]                        be_i,
  input  logic [31:0]                       wdata_i,
  output logic [31:0]                       rdata_o
);

  localparam int DEPTH = DMEM_BYTES / 4;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_mmio.sv
// RV32I load-store unit with DMEM and board I/O window; registered response.
// Define LSU_SW_SYNC_EN to pass io_sw_i through a 2-flop synchronizer.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int    DMEM_BYTES = 2048,
  parameter int    NUM_HEX    = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [2:0]             funct3_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            st_data_i,
  input  logic [31:0]            io_sw_i,
  output logic                   rsp_valid_o,
  output logic [31:0]            ld_data_o,
  output logic                   err_o,
  output logic [31:0]            io_ledr_o,
  output logic [31:0]            io_ledg_o,
  output logic [NUM_HEX*32-1:0]  io_hex_o,
  output logic [31:0]            io_lcd_o
);

  localparam int AW = $clog2(DMEM_BYTES / 4);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                        input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = w[8*b +: 8];
  endfunction

  logic [27:0]          slot;
  logic                 sel_ledr, sel_ledg, sel_lcd;
  logic [NUM_HEX-1:0]   hex_hit;
  lsu_region_e          region;
  logic                 bad, wr_ok, dmem_we;
  logic [3:0]           be;
  logic [31:0]          wdata, sw_val, rd_out, dmem_rdata;

  logic [31:0]          ledr_d, ledr_q, ledg_d, ledg_q, lcd_d, lcd_q;
  logic [NUM_HEX*32-1:0] hex_d, hex_q;
  logic                 rsp_valid_d, rsp_valid_q, err_d, err_q, load_ok_d, load_ok_q;
  lsu_region_e          region_d, region_q;
  logic [1:0]           lane_d, lane_q;
  logic [2:0]           f3_d, f3_q;
  logic [31:0]          io_rdata_d, io_rdata_q;

  assign slot     = addr_i[31:4];
  assign sel_ledr = (slot == SLOT_LEDR);
  assign sel_ledg = (slot == SLOT_LEDG);
  assign sel_lcd  = (slot == SLOT_LCD);

  always_comb begin
    hex_hit = '0;
    for (int i = 0; i < NUM_HEX; i++) hex_hit[i] = (slot == SLOT_HEX0 + 28'(i));
  end

  // DMEM wins first so nothing at or above DMEM_BYTES can alias back into it
  always_comb begin
    region = RGN_NONE;
    if (addr_i < 32'(DMEM_BYTES))                     region = RGN_DMEM;
    else if (slot == SLOT_SW)                         region = RGN_SW;
    else if (sel_ledr || sel_ledg || sel_lcd || |hex_hit) region = RGN_OUT;
  end

  always_comb begin
    case (funct3_i)
      LSU_B, LSU_BU: bad = 1'b0;
      LSU_H, LSU_HU: bad = addr_i[0];
      LSU_W:         bad = |addr_i[1:0];
      default:       bad = 1'b1;
    endcase
  end

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   begin be = 4'b0001 << addr_i[1:0];          wdata = {4{st_data_i[7:0]}};  end
      2'b01:   begin be = 4'b0011 << {addr_i[1], 1'b0};    wdata = {2{st_data_i[15:0]}}; end
      default: begin be = 4'b1111;                         wdata = st_data_i;            end
    endcase
  end

  assign wr_ok   = req_i & we_i & ~bad;
  assign dmem_we = wr_ok && (region == RGN_DMEM);

  lsu_dmem #(.DMEM_BYTES(DMEM_BYTES), .INIT_FILE(INIT_FILE)) u_dmem (
    .clk_i   (clk_i),
    .we_i    (dmem_we),
    .re_i    (req_i),
    .idx_i   (addr_i[AW+1:2]),
    .be_i    (be),
    .wdata_i (wdata),
    .rdata_o (dmem_rdata)
  );

`ifdef LSU_SW_SYNC_EN
  logic [31:0] sw_s1_q, sw_s2_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= io_sw_i;
      sw_s2_q <= sw_s1_q;
    end
  end
  assign sw_val = sw_s2_q;
`else
  assign sw_val = io_sw_i;
`endif

  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    lcd_d  = lcd_q;
    hex_d  = hex_q;
    if (wr_ok && sel_ledr) ledr_d = merge(ledr_q, wdata, be);
    if (wr_ok && sel_ledg) ledg_d = merge(ledg_q, wdata, be);
    if (wr_ok && sel_lcd)  lcd_d  = merge(lcd_q, wdata, be);
    for (int i = 0; i < NUM_HEX; i++) begin
      if (wr_ok && hex_hit[i]) hex_d[32*i +: 32] = merge(hex_q[32*i +: 32], wdata, be);
    end
  end

  always_comb begin
    rd_out = (sel_ledr ? ledr_q : 32'h0) | (sel_ledg ? ledg_q : 32'h0) |
             (sel_lcd  ? lcd_q  : 32'h0);
    for (int i = 0; i < NUM_HEX; i++) rd_out = rd_out | (hex_hit[i] ? hex_q[32*i +: 32] : 32'h0);
  end

  // Response context only moves on a request, so idle cycles hold ld_data_o/err_o
  always_comb begin
    rsp_valid_d = req_i;
    err_d       = err_q;
    load_ok_d   = load_ok_q;
    region_d    = region_q;
    lane_d      = lane_q;
    f3_d        = f3_q;
    io_rdata_d  = io_rdata_q;
    if (req_i) begin
      err_d     = bad;
      load_ok_d = ~we_i & ~bad;
      region_d  = region;
      lane_d    = addr_i[1:0];
      f3_d      = funct3_i;
      case (region)
        RGN_SW:  io_rdata_d = sw_val;
        RGN_OUT: io_rdata_d = rd_out;
        default: io_rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ledr_q      <= '0;
      ledg_q      <= '0;
      lcd_q       <= '0;
      hex_q       <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      load_ok_q   <= 1'b0;
      region_q    <= RGN_NONE;
      lane_q      <= '0;
      f3_q        <= '0;
      io_rdata_q  <= '0;
    end else begin
      ledr_q      <= ledr_d;
      ledg_q      <= ledg_d;
      lcd_q       <= lcd_d;
      hex_q       <= hex_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      load_ok_q   <= load_ok_d;
      region_q    <= region_d;
      lane_q      <= lane_d;
      f3_q        <= f3_d;
      io_rdata_q  <= io_rdata_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign err_o       = err_q;
  assign ld_data_o   = load_ok_q ?
                       lane_extract((region_q == RGN_DMEM) ? dmem_rdata : io_rdata_q, lane_q, f3_q) :
                       32'h0;
  assign io_ledr_o   = ledr_q;
  assign io_ledg_o   = ledg_q;
  assign io_hex_o    = hex_q;
  assign io_lcd_o    = lcd_q;

endmodule

// File: tb/tb_lsu_mmio.sv
// Directed bench for lsu_mmio: DMEM, extension, alignment, I/O window and async reset.
module tb_lsu_mmio;

  localparam int NUM_HEX = 8;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  req_i, we_i;
  logic [2:0]            funct3_i;
  logic [31:0]           addr_i, st_data_i, io_sw_i;
  logic                  rsp_valid_o, err_o;
  logic [31:0]           ld_data_o, io_ledr_o, io_ledg_o, io_lcd_o;
  logic [NUM_HEX*32-1:0] io_hex_o;

  int checks   = 0;
  int failures = 0;

  lsu_mmio #(.DMEM_BYTES(2048), .NUM_HEX(NUM_HEX), .INIT_FILE("")) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .st_data_i(st_data_i), .io_sw_i(io_sw_i),
    .rsp_valid_o(rsp_valid_o), .ld_data_o(ld_data_o), .err_o(err_o),
    .io_ledr_o(io_ledr_o), .io_ledg_o(io_ledg_o), .io_hex_o(io_hex_o), .io_lcd_o(io_lcd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive on the falling edge, sample 1 time unit after the accepting rising edge
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; st_data_i = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    @(negedge clk_i);
    req_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b010;
    addr_i = '0; st_data_i = '0; io_sw_i = 32'h0000_5A5A;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst_ld",    ld_data_o, 32'h0);
    chk("rst_err",   {31'h0, err_o}, 32'h0);
    chk("rst_ledr",  io_ledr_o, 32'h0);
    chk("rst_hex",   {31'h0, |io_hex_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // word store/load
    access(1'b1, 3'b010, 32'h100, 32'h1122_3344);
    chk("sw_valid", {31'h0, rsp_valid_o}, 32'h1);
    chk("sw_ld0",   ld_data_o, 32'h0);
    chk("sw_err",   {31'h0, err_o}, 32'h0);
    access(1'b0, 3'b010, 32'h100, 32'h0);
    chk("lw_valid", {31'h0, rsp_valid_o}, 32'h1);
    chk("lw_data",  ld_data_o, 32'h1122_3344);

    // byte store, sign/zero extension, half loads
    access(1'b1, 3'b000, 32'h103, 32'h0000_0080);
    access(1'b0, 3'b000, 32'h103, 32'h0);
    chk("lb_sext",  ld_data_o, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h103, 32'h0);
    chk("lbu_zext", ld_data_o, 32'h0000_0080);
    access(1'b0, 3'b010, 32'h100, 32'h0);
    chk("lw_merged", ld_data_o, 32'h8022_3344);
    access(1'b0, 3'b001, 32'h102, 32'h0);
    chk("lh_sext",  ld_data_o, 32'hFFFF_8022);
    access(1'b0, 3'b101, 32'h102, 32'h0);
    chk("lhu_zext", ld_data_o, 32'h0000_8022);

    // hold while idle
    idle();
    chk("idle_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("idle_hold",  ld_data_o, 32'h0000_8022);

    // misalignment and illegal funct3
    access(1'b1, 3'b001, 32'h101, 32'h0000_BEEF);
    chk("sh_mis_err", {31'h0, err_o}, 32'h1);
    chk("sh_mis_ld",  ld_data_o, 32'h0);
    access(1'b0, 3'b010, 32'h102, 32'h0);
    chk("lw_mis_err", {31'h0, err_o}, 32'h1);
    chk("lw_mis_ld",  ld_data_o, 32'h0);
    access(1'b0, 3'b010, 32'h100, 32'h0);
    chk("mis_unchanged", ld_data_o, 32'h8022_3344);
    chk("aligned_err",   {31'h0, err_o}, 32'h0);
    access(1'b0, 3'b011, 32'h100, 32'h0);
    chk("illegal_f3_err", {31'h0, err_o}, 32'h1);
    chk("illegal_f3_ld",  ld_data_o, 32'h0);

    // HEX 3 and LEDR byte lane
    access(1'b1, 3'b010, 32'h7050, 32'h0000_00A5);
    chk("hex3_val", io_hex_o[127:96], 32'h0000_00A5);
    for (int i = 0; i < NUM_HEX; i++) begin
      if (i != 3) chk($sformatf("hex%0d_zero", i), io_hex_o[32*i +: 32], 32'h0);
    end
    access(1'b0, 3'b010, 32'h7050, 32'h0);
    chk("hex3_rd", ld_data_o, 32'h0000_00A5);
    access(1'b0, 3'b010, 32'h705C, 32'h0);
    chk("hex3_rd_alias", ld_data_o, 32'h0000_00A5);
    access(1'b1, 3'b000, 32'h7001, 32'h0000_0012);
    chk("ledr_byte", io_ledr_o, 32'h0000_1200);
    access(1'b0, 3'b100, 32'h7001, 32'h0);
    chk("ledr_lbu", ld_data_o, 32'h0000_0012);
    chk("ledg_zero", io_ledg_o, 32'h0);
    access(1'b1, 3'b010, 32'h7100, 32'h0000_0C0D);
    chk("lcd_val", io_lcd_o, 32'h0000_0C0D);

    // switches, unmapped, DMEM boundary
    io_sw_i = 32'h0000_5A5A;
    idle();
    idle();
    access(1'b0, 3'b010, 32'h7800, 32'h0);
    chk("sw_rd", ld_data_o, 32'h0000_5A5A);
    access(1'b1, 3'b010, 32'h7800, 32'hFFFF_FFFF);
    chk("sw_store_err", {31'h0, err_o}, 32'h0);
    access(1'b0, 3'b010, 32'h7800, 32'h0);
    chk("sw_rd_after", ld_data_o, 32'h0000_5A5A);
    access(1'b0, 3'b010, 32'h4000, 32'h0);
    chk("unmapped_ld",  ld_data_o, 32'h0);
    chk("unmapped_err", {31'h0, err_o}, 32'h0);
    access(1'b1, 3'b010, 32'h0, 32'hCAFE_0000);
    access(1'b1, 3'b010, 32'h800, 32'h0000_DEAD);
    access(1'b0, 3'b010, 32'h800, 32'h0);
    chk("edge_unmapped", ld_data_o, 32'h0);
    access(1'b0, 3'b010, 32'h0, 32'h0);
    chk("edge_no_alias", ld_data_o, 32'hCAFE_0000);

    // async reset in the middle of back-to-back traffic
    access(1'b0, 3'b010, 32'h100, 32'h0);
    access(1'b0, 3'b010, 32'h0, 32'h0);
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("arst_ld",    ld_data_o, 32'h0);
    chk("arst_ledr",  io_ledr_o, 32'h0);
    chk("arst_lcd",   io_lcd_o, 32'h0);
    chk("arst_hex",   {31'h0, |io_hex_o}, 32'h0);
    @(negedge clk_i);
    req_i = 1'b0;
    rst_ni = 1'b1;
    access(1'b0, 3'b010, 32'h100, 32'h0);
    chk("dmem_kept", ld_data_o, 32'h8022_3344);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
